// File: rtl/morse_round_ctrl_pkg.sv
// Shared types and defaults for the Morse training game round controller.
package morse_round_ctrl_pkg;

  localparam int ADDR_W          = 5;
  localparam int NUM_LETTERS_DEF = 26;
  localparam int LIVES_INIT_DEF  = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_WAIT     = 3'd2,
    ST_RESULT   = 3'd3,
    ST_GAMEOVER = 3'd4
  } state_e;

endpackage

// File: rtl/morse_round_ctrl_round_result_upd.sv
// Next score (saturating), next lives and next letter index (wrapping)
// for one resolved round.
module round_result_upd
  import morse_round_ctrl_pkg::*;
#(
  parameter int NUM_LETTERS = NUM_LETTERS_DEF,
  parameter int SCORE_W     = 7
) (
  input  logic               hit_i,
  input  logic [SCORE_W-1:0] score_i,
  input  logic [1:0]         lives_i,
  input  logic [ADDR_W-1:0]  addr_i,
  output logic [SCORE_W-1:0] score_o,
  output logic [1:0]         lives_o,
  output logic [ADDR_W-1:0]  addr_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_LETTERS - 1);

  always_comb begin
    score_o = score_i;
    lives_o = lives_i;
    if (hit_i) begin
      if (score_i != '1) score_o = score_i + 1'b1;
    end else begin
      if (lives_i != 2'd0) lives_o = lives_i - 2'd1;
    end
    addr_o = (addr_i == LAST) ? '0 : addr_i + 1'b1;
  end

endmodule

// File: rtl/morse_round_ctrl.sv
// Round sequencer for the Morse game: letter select, score, lives and
// round timer control.
module morse_round_ctrl
  import morse_round_ctrl_pkg::*;
#(
  parameter int NUM_LETTERS = NUM_LETTERS_DEF,
  parameter int LIVES_INIT  = LIVES_INIT_DEF,
  parameter int SCORE_W     = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               timer_timeout,
  input  logic               answer_valid,
  input  logic               answer_correct,
  output logic               timer_enable,
  output logic               timer_clear,
  output logic [ADDR_W-1:0]  rom_addr,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic               round_active,
  output logic               game_over
);

  state_e               state_q, state_d;
  logic [SCORE_W-1:0]   score_q, score_d, score_n;
  logic [1:0]           lives_q, lives_d, lives_n;
  logic [ADDR_W-1:0]    addr_q, addr_d, addr_n;
  logic                 hit;

  // Answer wins over a coincident timeout.
  assign hit = answer_valid & answer_correct;

  round_result_upd #(
    .NUM_LETTERS(NUM_LETTERS),
    .SCORE_W    (SCORE_W)
  ) u_upd (
    .hit_i  (hit),
    .score_i(score_q),
    .lives_i(lives_q),
    .addr_i (addr_q),
    .score_o(score_n),
    .lives_o(lives_n),
    .addr_o (addr_n)
  );

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    addr_d  = addr_q;
    unique case (state_q)
      ST_IDLE, ST_GAMEOVER: begin
        if (start) begin
          state_d = ST_LOAD;
          score_d = '0;
          lives_d = 2'(LIVES_INIT);
          addr_d  = '0;
        end
      end
      ST_LOAD: state_d = ST_WAIT;
      ST_WAIT: begin
        if (answer_valid || timer_timeout) begin
          state_d = ST_RESULT;
          score_d = score_n;
          lives_d = lives_n;
          addr_d  = addr_n;
        end
      end
      ST_RESULT:
        state_d = (lives_q == 2'd0) ? ST_GAMEOVER : ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      score_q <= '0;
      lives_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      lives_q <= lives_d;
      addr_q  <= addr_d;
    end
  end

  assign timer_clear  = (state_q == ST_LOAD);
  assign timer_enable = (state_q == ST_WAIT);
  assign round_active = (state_q == ST_WAIT);
  assign game_over    = (state_q == ST_GAMEOVER);
  assign rom_addr     = addr_q;
  assign score        = score_q;
  assign lives        = lives_q;

endmodule
